ps2_key_controller: RTL
=======================

Name: ps2_key_controller

Overview:
Sequencer between the PS/2 byte receiver and the ARM-Racer game logic. It consumes received scan-code bytes and tracks the E0 (extended) and F0 (break) prefixes with a state machine. It keeps a held/released bitmap of the racer control keys and queues decoded key events in a small FIFO with a valid/ready handshake toward the game core.

Parameters:
- DEPTH, 4: event FIFO entries (power of 2, min 2)
- TIMEOUT_CYC, 100000: idle cycles after a prefix before the FSM abandons the sequence (2 ms at 50 MHz)

Ports:
- CLK  in  1  board clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- RX_DATA  in  8  received scan-code byte
- RX_VALID  in  1  one-cycle strobe, RX_DATA valid
- RX_ERR  in  1  parity/framing error for the byte strobed with RX_VALID
- EVT_CODE  out  8  head event scan code (prefixes stripped)
- EVT_EXT  out  1  head event was E0-prefixed
- EVT_BREAK  out  1  head event is a release
- EVT_VALID  out  1  FIFO not empty
- EVT_READY  in  1  consumer accepts head event
- KEY_STATE  out  4  held bitmap {UP,DOWN,LEFT,RIGHT}
- KEY_COUNT  out  8  count of new presses of tracked keys
- OVERFLOW  out  1  sticky: an event was dropped on a full FIFO

Behaviour:
- Reset: FSM=IDLE, FIFO empty, EVT_VALID=0, EVT_CODE=0, EVT_EXT=0, EVT_BREAK=0, KEY_STATE=0, KEY_COUNT=0, OVERFLOW=0, timeout counter=0. Reset mid-sequence discards any partial prefix and all queued events.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Bytes are processed only when RX_VALID=1.
- IDLE:
  - E0 -> GOT_E0
  - F0 -> GOT_F0
  - 00 or FF -> ignored, stay IDLE
  - any other byte -> emit make (ext=0), stay IDLE
- GOT_E0:
  - F0 -> GOT_E0F0
  - E0 -> stay, timer restarts
  - other -> emit make (ext=1), go IDLE
- GOT_F0:
  - E0 -> GOT_E0
  - F0 -> stay
  - other -> emit break (ext=0), go IDLE
- GOT_E0F0:
  - E0 or F0 -> go IDLE, no event
  - other -> emit break (ext=1), go IDLE
- RX_VALID with RX_ERR=1: byte discarded, FSM -> IDLE, no event, no KEY_STATE change.
- Timeout counter:
  - clears on every RX_VALID and while in IDLE
  - increments in the other states
  - on reaching TIMEOUT_CYC-1 the FSM -> IDLE next edge and the counter clears
- Latency: the event is written at the same edge that samples RX_VALID; EVT_VALID is high from the next cycle. KEY_STATE updates on that same edge.
- Tracked keys (make sets the bit, break clears it):
  - UP: E0 75 or 1D (W)
  - DOWN: E0 72 or 1B (S)
  - LEFT: E0 6B or 1C (A)
  - RIGHT: E0 74 or 23 (D)
  - Both sources of a direction share one bit; the last event wins.
- KEY_COUNT increments only on a 0->1 bit transition. Typematic repeat makes do not count. Wraps 255->0.
- FIFO entry = {ext, brk, code}. EVT_* outputs show the head entry; they are 0 when empty.
  - Pop on EVT_VALID & EVT_READY.
  - Push when full with no pop the same cycle: event dropped, OVERFLOW=1 until RST. KEY_STATE and KEY_COUNT still update.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - EVT_READY while empty: no effect.
- Untracked codes are queued normally but never touch KEY_STATE.

Decomposition:
- Shared package ps2_pkg holds:
  - prefix constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0
  - tracked key code constants
  - KEY_STATE bit indices
  - FSM state encoding
  - event entry width (10)
- Sub-module ps2_evt_fifo: synchronous FIFO, parameter DEPTH, with push/pop/full/empty and the simultaneous push/pop rule above. The top level holds the FSM, timeout counter, key bitmap and KEY_COUNT.

Test Plan:
- RST high 2 cycles, then low -> all outputs 0. Byte 1C -> next cycle EVT_VALID=1, EVT_CODE=1C, EVT_EXT=0, EVT_BREAK=0, KEY_STATE=0010, KEY_COUNT=1.
- Bytes E0,75 then E0,F0,75, EVT_READY=1 -> events {1,0,75} then {1,1,75}. KEY_STATE bit3 rises then falls. KEY_COUNT=1.
- Byte 1D sent 3 times (typematic) -> 3 make events queued, KEY_COUNT=1, KEY_STATE=1000.
- E0 then no byte for TIMEOUT_CYC cycles, then 75 -> event {0,0,75} (not extended), KEY_STATE unchanged.
- EVT_READY=0, 5 makes with DEPTH=4 -> 4 queued, OVERFLOW=1. Then EVT_READY=1 plus a new byte in the same cycle as a pop while full -> both accepted, count stays 4.
- F0 strobed with RX_ERR=1, then 23 -> make {0,0,23}, not a break. Separately, RST asserted in GOT_E0F0 -> IDLE, FIFO empty.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key controller slice.
// Prefix bytes, tracked key codes, key bitmap indices, FSM encoding, event layout.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [7:0] KEY_UP_EXT    = 8'h75;
    localparam logic [7:0] KEY_DOWN_EXT  = 8'h72;
    localparam logic [7:0] KEY_LEFT_EXT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT_EXT = 8'h74;
    localparam logic [7:0] KEY_W         = 8'h1D;
    localparam logic [7:0] KEY_S         = 8'h1B;
    localparam logic [7:0] KEY_A         = 8'h1C;
    localparam logic [7:0] KEY_D         = 8'h23;

    localparam int KEY_UP    = 3;
    localparam int KEY_DOWN  = 2;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_RIGHT = 0;

    localparam int EVT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GOT_E0,
        ST_GOT_F0,
        ST_GOT_E0F0
    } ps2_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    // Arrow keys only count when E0-prefixed; WASD only when not.
    function automatic logic [3:0] key_mask(input logic ext, input logic [7:0] code);
        key_mask = '0;
        if (ext) begin
            case (code)
                KEY_UP_EXT:    key_mask[KEY_UP]    = 1'b1;
                KEY_DOWN_EXT:  key_mask[KEY_DOWN]  = 1'b1;
                KEY_LEFT_EXT:  key_mask[KEY_LEFT]  = 1'b1;
                KEY_RIGHT_EXT: key_mask[KEY_RIGHT] = 1'b1;
                default: ;
            endcase
        end else begin
            case (code)
                KEY_W: key_mask[KEY_UP]    = 1'b1;
                KEY_S: key_mask[KEY_DOWN]  = 1'b1;
                KEY_A: key_mask[KEY_LEFT]  = 1'b1;
                KEY_D: key_mask[KEY_RIGHT] = 1'b1;
                default: ;
            endcase
        end
    endfunction

endpackage

// File: rtl/ps2_key_controller_if.sv
// Byte-in / event-out bundle between the PS/2 receiver, the key controller and the game core.
// master drives received bytes and consumer ready; slave is the key controller.
interface ps2_key_controller_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] key_state;
    logic [7:0] key_count;
    logic       overflow;

    modport master (
        output rx_data, rx_valid, rx_err, evt_ready,
        input  evt_code, evt_ext, evt_break, evt_valid, key_state, key_count, overflow
    );

    modport slave (
        input  rx_data, rx_valid, rx_err, evt_ready,
        output evt_code, evt_ext, evt_break, evt_valid, key_state, key_count, overflow
    );
endinterface

// File: rtl/ps2_evt_fifo.sv
// Purpose: small synchronous FIFO of decoded key events; head is zero while empty.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push on full without a same-cycle pop is dropped and flagged on drop.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  evt_t push_dat,
    input  logic pop,
    output evt_t head,
    output logic empty,
    output logic drop
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    evt_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop on the same edge frees the slot, so a full FIFO still takes the push.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_controller.sv
// Purpose: strips E0/F0 prefixes from PS/2 bytes, tracks racer key bitmap, queues key events.
// Latency: event written and KEY_STATE updated on the edge that samples rx_valid; evt_valid next cycle.
// Backpressure: evt_valid/evt_ready to the game core; events arriving on a full queue are dropped (sticky overflow).
module ps2_key_controller
    import ps2_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    ps2_key_controller_if.slave  bus
);
    localparam int               TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYC - 1);

    ps2_state_t    state;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    key_state;
    logic [7:0]    key_count;
    logic          overflow;

    logic          is_prefix;
    logic          emit;
    evt_t          emit_evt;
    logic [3:0]    emit_mask;
    evt_t          head;
    logic          fifo_empty;
    logic          fifo_drop;

    assign is_prefix = (bus.rx_data == PS2_EXT) || (bus.rx_data == PS2_BRK);

    // Event decode is combinational so the FIFO captures it on the sampling edge.
    always_comb begin
        emit         = 1'b0;
        emit_evt     = '0;
        emit_evt.ext = (state == ST_GOT_E0) || (state == ST_GOT_E0F0);
        emit_evt.brk = (state == ST_GOT_F0) || (state == ST_GOT_E0F0);
        emit_evt.code = bus.rx_data;
        if (bus.rx_valid && !bus.rx_err && !is_prefix) begin
            emit = !((state == ST_IDLE) &&
                     ((bus.rx_data == 8'h00) || (bus.rx_data == 8'hFF)));
        end
    end

    assign emit_mask = emit ? key_mask(emit_evt.ext, emit_evt.code) : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            key_state <= '0;
            key_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (fifo_drop) overflow <= 1'b1;

            if (emit_mask != 4'b0000) begin
                if (emit_evt.brk) begin
                    key_state <= key_state & ~emit_mask;
                end else begin
                    key_state <= key_state | emit_mask;
                    if ((key_state & emit_mask) == 4'b0000) key_count <= key_count + 1'b1;
                end
            end

            if (bus.rx_valid) begin
                tmo_cnt <= '0;
                if (bus.rx_err) begin
                    state <= ST_IDLE;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (bus.rx_data == PS2_EXT)      state <= ST_GOT_E0;
                            else if (bus.rx_data == PS2_BRK) state <= ST_GOT_F0;
                        end
                        ST_GOT_E0: begin
                            if (bus.rx_data == PS2_BRK)      state <= ST_GOT_E0F0;
                            else if (bus.rx_data != PS2_EXT) state <= ST_IDLE;
                        end
                        ST_GOT_F0: begin
                            if (bus.rx_data == PS2_EXT)      state <= ST_GOT_E0;
                            else if (bus.rx_data != PS2_BRK) state <= ST_IDLE;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end else if (state == ST_IDLE) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_LAST) begin
                state   <= ST_IDLE;
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    ps2_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (emit),
        .push_dat (emit_evt),
        .pop      (bus.evt_ready),
        .head     (head),
        .empty    (fifo_empty),
        .drop     (fifo_drop)
    );

    assign bus.evt_code  = head.code;
    assign bus.evt_ext   = head.ext;
    assign bus.evt_break = head.brk;
    assign bus.evt_valid = ~fifo_empty;
    assign bus.key_state = key_state;
    assign bus.key_count = key_count;
    assign bus.overflow  = overflow;

endmodule
